// File: rtl/frt_int_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : frt_int_arb_if
// Description : Internal peripheral bus bundle for the FRT interrupt arbiter.
//               The CPU side drives the address, write data, write strobe and
//               access strobe. The arbiter returns read data and an
//               address-hit flag.
//   Signals   : IBUS_A   [31:0] address
//               IBUS_DI  [31:0] write data
//               IBUS_WE         write
//               IBUS_REQ        access strobe
//               IBUS_DO  [31:0] read data (from the block)
//               IBUS_ACT        address falls inside this block
// Revision    : 1.0 - initial release
// ============================================================================
interface frt_int_arb_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic [31:0] IBUS_DO;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A,
        output IBUS_DI,
        output IBUS_WE,
        output IBUS_REQ,
        input  IBUS_DO,
        input  IBUS_ACT
    );

    modport slave (
        input  IBUS_A,
        input  IBUS_DI,
        input  IBUS_WE,
        input  IBUS_REQ,
        output IBUS_DO,
        output IBUS_ACT
    );
endinterface
`default_nettype wire

// File: rtl/frt_int_arb.sv
`default_nettype none
// ============================================================================
// Module      : frt_int_arb
// Description : Interrupt arbiter for the free-running timer. It chooses one of
//               four level-sensitive sources (ICI > OCIA > OCIB > OVI), shows
//               it to the CPU with a programmable level and vector, and keeps
//               the request low after acknowledge until the handler clears the
//               source flag.
//   Ports     : CLK, RST (sync, active-high), CE_R (clock enable)
//               bus         register access (FPRI @ FPRI_ADDR, FVEC @ FVEC_ADDR)
//               *_IRQ       timer interrupt sources
//               IMASK       CPU interrupt mask level
//               INT_ACK     CPU accepts the presented request
//               INT_REQ/INT_LVL/INT_VEC   request presented to the CPU
//               ACK_SRC     one-cycle one-hot acknowledge {ICI,OCIA,OCIB,OVI}
// Revision    : 1.0 - initial release
// ============================================================================
module frt_int_arb #(
    parameter logic [31:0] FPRI_ADDR = 32'hFFFF_FE60,
    parameter logic [31:0] FVEC_ADDR = 32'hFFFF_FE64
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic        CE_R,
    frt_int_arb_if.slave     bus,
    input  wire logic        ICI_IRQ,
    input  wire logic        OCIA_IRQ,
    input  wire logic        OCIB_IRQ,
    input  wire logic        OVI_IRQ,
    input  wire logic [3:0]  IMASK,
    input  wire logic        INT_ACK,
    output logic             INT_REQ,
    output logic [3:0]       INT_LVL,
    output logic [6:0]       INT_VEC,
    output logic [3:0]       ACK_SRC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Programmable registers
    // ------------------------------------------------------------------------
    logic [3:0] lvl;
    logic [6:0] icv;
    logic [6:0] ocv;
    logic [6:0] ovv;

    logic hit_fpri;
    logic hit_fvec;
    logic wr_en;

    assign hit_fpri = (bus.IBUS_A == FPRI_ADDR);
    assign hit_fvec = (bus.IBUS_A == FVEC_ADDR);
    assign wr_en    = CE_R & bus.IBUS_REQ & bus.IBUS_WE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lvl <= 4'd0;
            icv <= 7'd0;
            ocv <= 7'd0;
            ovv <= 7'd0;
        end else if (wr_en) begin
            if (hit_fpri) begin
                lvl <= bus.IBUS_DI[27:24];
            end
            if (hit_fvec) begin
                icv <= bus.IBUS_DI[30:24];
                ocv <= bus.IBUS_DI[22:16];
                ovv <= bus.IBUS_DI[14:8];
            end
        end
    end

    // Read path is purely combinational on address; the strobe only qualifies
    // writes.
    assign bus.IBUS_ACT = hit_fpri | hit_fvec;

    always_comb begin
        bus.IBUS_DO = 32'd0;
        if (hit_fpri) begin
            bus.IBUS_DO = {4'd0, lvl, 24'd0};
        end else if (hit_fvec) begin
            bus.IBUS_DO = {1'b0, icv, 1'b0, ocv, 1'b0, ovv, 8'd0};
        end
    end

    // Data bits that are reserved in both registers.
    logic unused_di;
    assign unused_di = ^{bus.IBUS_DI[31], bus.IBUS_DI[23], bus.IBUS_DI[15],
                         bus.IBUS_DI[7:0]};

    // ------------------------------------------------------------------------
    // Eligibility and fixed-priority selection
    // ------------------------------------------------------------------------
    // Source vector order matches ACK_SRC: [3]=ICI [2]=OCIA [1]=OCIB [0]=OVI.
    logic [3:0] irq;
    logic       lvl_ok;
    logic [3:0] elig;

    assign irq    = {ICI_IRQ, OCIA_IRQ, OCIB_IRQ, OVI_IRQ};
    assign lvl_ok = (lvl != 4'd0) && (lvl > IMASK);
    assign elig   = irq & {4{lvl_ok}};

    logic [3:0] win;
    logic [6:0] win_vec;

    always_comb begin
        win     = 4'b0000;
        win_vec = 7'd0;
        if (elig[3]) begin
            win     = 4'b1000;
            win_vec = icv;
        end else if (elig[2]) begin
            win     = 4'b0100;
            win_vec = ocv;
        end else if (elig[1]) begin
            win     = 4'b0010;
            win_vec = ocv;
        end else if (elig[0]) begin
            win     = 4'b0001;
            win_vec = ovv;
        end
    end

    // ------------------------------------------------------------------------
    // Request / acknowledge sequencer
    // ------------------------------------------------------------------------
    state_t     state;
    logic [3:0] src;        // one-hot source being served (kept through HOLD)
    logic       src_elig;
    logic       src_irq;

    // Reduction against the latched one-hot source: the served source only,
    // never whichever source happens to be winning now.
    assign src_elig = |(src & elig);
    assign src_irq  = |(src & irq);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            src     <= 4'b0000;
            INT_REQ <= 1'b0;
            INT_LVL <= 4'd0;
            INT_VEC <= 7'd0;
            ACK_SRC <= 4'b0000;
        end else if (CE_R) begin
            // Acknowledge is a single-cycle pulse unless re-armed below.
            ACK_SRC <= 4'b0000;
            case (state)
                IDLE: begin
                    // INT_ACK is deliberately ignored here.
                    if (|win) begin
                        src     <= win;
                        INT_REQ <= 1'b1;
                        INT_LVL <= lvl;
                        INT_VEC <= win_vec;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    // Acknowledge is tested first so that a source dropping in
                    // the same cycle still gets its pulse. Higher-priority
                    // sources appearing here wait: no preemption.
                    if (INT_ACK) begin
                        ACK_SRC <= src;
                        INT_REQ <= 1'b0;
                        INT_LVL <= 4'd0;
                        INT_VEC <= 7'd0;
                        state   <= HOLD;
                    end else if (!src_elig) begin
                        src     <= 4'b0000;
                        INT_REQ <= 1'b0;
                        INT_LVL <= 4'd0;
                        INT_VEC <= 7'd0;
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    // Wait for the handler to clear the flag so the same event
                    // is not requested twice.
                    if (!src_irq) begin
                        src   <= 4'b0000;
                        state <= IDLE;
                    end
                end
                default: begin
                    src     <= 4'b0000;
                    INT_REQ <= 1'b0;
                    INT_LVL <= 4'd0;
                    INT_VEC <= 7'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frt_int_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_frt_int_arb
// Description : Self-checking bench for frt_int_arb. A table of per-cycle
//               vectors drives the bus, sources, mask and acknowledge, then
//               compares the combinational read path (before the edge) and the
//               registered request outputs (after the edge). Hand-written
//               sequences cover reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frt_int_arb;

    localparam logic [31:0] A60 = 32'hFFFF_FE60;
    localparam logic [31:0] A64 = 32'hFFFF_FE64;
    localparam logic [31:0] A68 = 32'hFFFF_FE68;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE_R = 1'b1;
    logic [3:0] irq = 4'b0000;
    logic [3:0] IMASK = 4'd3;
    logic       INT_ACK = 1'b0;
    logic       INT_REQ;
    logic [3:0] INT_LVL;
    logic [6:0] INT_VEC;
    logic [3:0] ACK_SRC;

    int checks = 0;
    int failures = 0;

    frt_int_arb_if bus ();

    frt_int_arb dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE_R     (CE_R),
        .bus      (bus),
        .ICI_IRQ  (irq[3]),
        .OCIA_IRQ (irq[2]),
        .OCIB_IRQ (irq[1]),
        .OVI_IRQ  (irq[0]),
        .IMASK    (IMASK),
        .INT_ACK  (INT_ACK),
        .INT_REQ  (INT_REQ),
        .INT_LVL  (INT_LVL),
        .INT_VEC  (INT_VEC),
        .ACK_SRC  (ACK_SRC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        ce;
        logic        req;
        logic        we;
        logic [31:0] a;
        logic [31:0] di;
        logic [3:0]  irq;
        logic [3:0]  imask;
        logic        ack;
        logic [31:0] exp_do;
        logic        exp_act;
        logic        exp_req;
        logic [3:0]  exp_lvl;
        logic [6:0]  exp_vec;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic ce, logic req, logic we,
                                logic [31:0] a, logic [31:0] di, logic [3:0] s,
                                logic [3:0] m, logic ack, logic [31:0] edo,
                                logic eact, logic ereq, logic [3:0] elvl,
                                logic [6:0] evec, logic [3:0] eack);
        vec_t t;
        t.name = name; t.ce = ce; t.req = req; t.we = we; t.a = a; t.di = di;
        t.irq = s; t.imask = m; t.ack = ack; t.exp_do = edo; t.exp_act = eact;
        t.exp_req = ereq; t.exp_lvl = elvl; t.exp_vec = evec; t.exp_ack = eack;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] di,
                         input logic [3:0] s, input logic [3:0] m,
                         input logic ack);
        CE_R = ce;
        bus.IBUS_REQ = req;
        bus.IBUS_WE = we;
        bus.IBUS_A = a;
        bus.IBUS_DI = di;
        irq = s;
        IMASK = m;
        INT_ACK = ack;
    endtask

    task automatic check_outs(input string name, input logic r,
                              input logic [3:0] l, input logic [6:0] v,
                              input logic [3:0] k);
        check({name, "/req"}, 32'(INT_REQ), 32'(r));
        check({name, "/lvl"}, 32'(INT_LVL), 32'(l));
        check({name, "/vec"}, 32'(INT_VEC), 32'(v));
        check({name, "/ack_src"}, 32'(ACK_SRC), 32'(k));
    endtask

    task automatic apply(input vec_t t);
        @(negedge CLK);
        drive(t.ce, t.req, t.we, t.a, t.di, t.irq, t.imask, t.ack);
        #1;
        check({t.name, "/do"}, bus.IBUS_DO, t.exp_do);
        check({t.name, "/act"}, 32'(bus.IBUS_ACT), 32'(t.exp_act));
        @(posedge CLK);
        #1;
        check_outs(t.name, t.exp_req, t.exp_lvl, t.exp_vec, t.exp_ack);
    endtask

    initial begin
        // Register setup and read path
        //                 name          ce req we addr  data          irq   msk ack  do            act req lvl vec    ack_src
        vecs.push_back(mk("wr_fpri",     1, 1, 1, A60, 32'hF5FF_FFFF, 4'h0, 3, 0, 32'h0,        1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("wr_fvec_1s",  1, 1, 1, A64, 32'hFFFF_FFFF, 4'h0, 3, 0, 32'h0,        1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rd_fvec_msk", 1, 1, 0, A64, 32'h0,         4'h0, 3, 0, 32'h7F7F7F00, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("wr_fvec",     1, 1, 1, A64, 32'h4022_1100, 4'h0, 3, 0, 32'h7F7F7F00, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rd_fpri",     1, 1, 0, A60, 32'h0,         4'h0, 3, 0, 32'h05000000, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rd_fvec",     1, 1, 0, A64, 32'h0,         4'h0, 3, 0, 32'h40221100, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rd_miss",     1, 1, 0, A68, 32'h0,         4'h0, 3, 0, 32'h0,        0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("idle_ack",    1, 0, 0, 0,   32'h0,         4'h0, 3, 1, 32'h0,        0, 0, 0, 7'h00, 4'h0));
        // ICI request, acknowledge, hold until cleared
        vecs.push_back(mk("ici_rise",    1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ici_pend",    1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ici_ack",     1, 0, 0, 0, 0, 4'h8, 3, 1, 0, 0, 0, 0, 7'h00, 4'h8));
        vecs.push_back(mk("ici_hold",    1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ici_hold2",   1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ici_clr",     1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        // OCIB and OVI together, then OVI after OCIB clears
        vecs.push_back(mk("ocib_ovi",    1, 0, 0, 0, 0, 4'h3, 3, 0, 0, 0, 1, 5, 7'h22, 4'h0));
        vecs.push_back(mk("ocib_ack",    1, 0, 0, 0, 0, 4'h3, 3, 1, 0, 0, 0, 0, 7'h00, 4'h2));
        vecs.push_back(mk("ocib_hold",   1, 0, 0, 0, 0, 4'h3, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ocib_clr",    1, 0, 0, 0, 0, 4'h1, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ovi_pend",    1, 0, 0, 0, 0, 4'h1, 3, 0, 0, 0, 1, 5, 7'h11, 4'h0));
        // No preemption by ICI while OVI is pending
        vecs.push_back(mk("no_preempt",  1, 0, 0, 0, 0, 4'h9, 3, 0, 0, 0, 1, 5, 7'h11, 4'h0));
        vecs.push_back(mk("ovi_ack",     1, 0, 0, 0, 0, 4'h9, 3, 1, 0, 0, 0, 0, 7'h00, 4'h1));
        vecs.push_back(mk("ovi_clr",     1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ici_after",   1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ici_ack2",    1, 0, 0, 0, 0, 4'h8, 3, 1, 0, 0, 0, 0, 7'h00, 4'h8));
        vecs.push_back(mk("ici_clr2",    1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        // OCIA cancel without acknowledge
        vecs.push_back(mk("ocia_pend",   1, 0, 0, 0, 0, 4'h4, 3, 0, 0, 0, 1, 5, 7'h22, 4'h0));
        vecs.push_back(mk("ocia_cancel", 1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("post_cancel", 1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        // Acknowledge and drop in the same cycle
        vecs.push_back(mk("ocia_pend2",  1, 0, 0, 0, 0, 4'h4, 3, 0, 0, 0, 1, 5, 7'h22, 4'h0));
        vecs.push_back(mk("ack_drop",    1, 0, 0, 0, 0, 4'h0, 3, 1, 0, 0, 0, 0, 7'h00, 4'h4));
        vecs.push_back(mk("hold_exit",   1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("idle_again",  1, 0, 0, 0, 0, 4'h4, 3, 0, 0, 0, 1, 5, 7'h22, 4'h0));
        vecs.push_back(mk("cancel2",     1, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        // LVL equal to mask blocks; raising LVL requests two cycles later
        vecs.push_back(mk("wr_lvl3",     1, 1, 1, A60, 32'h0300_0000, 4'h0, 3, 0, 32'h05000000, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("lvl_eq_msk",  1, 0, 0, 0,   0,             4'h1, 3, 0, 0,            0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("wr_lvl4",     1, 1, 1, A60, 32'h0400_0000, 4'h1, 3, 0, 32'h03000000, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("lvl4_req",    1, 0, 0, 0,   0,             4'h1, 3, 0, 0,            0, 1, 4, 7'h11, 4'h0));
        // Register writes while pending
        vecs.push_back(mk("wr_fvec_pnd", 1, 1, 1, A64, 32'h0,         4'h1, 3, 0, 32'h40221100, 1, 1, 4, 7'h11, 4'h0));
        vecs.push_back(mk("wr_lvl3_pnd", 1, 1, 1, A60, 32'h0300_0000, 4'h1, 3, 0, 32'h04000000, 1, 1, 4, 7'h11, 4'h0));
        vecs.push_back(mk("lvl3_cancel", 1, 1, 0, A64, 32'h0,         4'h1, 3, 0, 32'h0,        1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rst_lvl",     1, 1, 1, A60, 32'h0500_0000, 4'h0, 3, 0, 32'h03000000, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("rst_fvec",    1, 1, 1, A64, 32'h4022_1100, 4'h0, 3, 0, 32'h0,        1, 0, 0, 7'h00, 4'h0));
        // IMASK boundary
        vecs.push_back(mk("mask_eq",     1, 0, 0, 0, 0, 4'h8, 5, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("mask_below",  1, 0, 0, 0, 0, 4'h8, 4, 0, 0, 0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("mask_raise",  1, 0, 0, 0, 0, 4'h8, 5, 0, 0, 0, 0, 0, 7'h00, 4'h0));
        // Clock enable hold
        vecs.push_back(mk("ce0_idle",    0, 0, 0, 0,   0,             4'h8, 3, 0, 0,            0, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ce1_req",     1, 0, 0, 0,   0,             4'h8, 3, 0, 0,            0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ce0_ack",     0, 0, 0, 0,   0,             4'h8, 3, 1, 0,            0, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ce0_wr",      0, 1, 1, A60, 32'h0700_0000, 4'h8, 3, 0, 32'h05000000, 1, 1, 5, 7'h40, 4'h0));
        vecs.push_back(mk("ce1_ack",     1, 0, 0, 0,   0,             4'h8, 3, 1, 0,            0, 0, 0, 7'h00, 4'h8));
        vecs.push_back(mk("ce0_pulse",   0, 0, 0, 0,   0,             4'h8, 3, 0, 0,            0, 0, 0, 7'h00, 4'h8));
        vecs.push_back(mk("ce1_pls_end", 1, 1, 0, A60, 0,             4'h8, 3, 0, 32'h05000000, 1, 0, 0, 7'h00, 4'h0));
        vecs.push_back(mk("ce1_clr",     1, 0, 0, 0,   0,             4'h0, 3, 0, 0,            0, 0, 0, 7'h00, 4'h0));

        // Initial reset with CE_R low: reset must still take effect.
        drive(0, 0, 0, 0, 0, 4'h8, 3, 1);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_outs("reset", 0, 0, 7'h00, 4'h0);
        bus.IBUS_REQ = 1'b1;
        bus.IBUS_A = A60;
        #1;
        check("reset/fpri", bus.IBUS_DO, 32'h0);
        bus.IBUS_A = A64;
        #1;
        check("reset/fvec", bus.IBUS_DO, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 0, 0, 0, 0, 4'h0, 3, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while pending aborts without an acknowledge pulse.
        apply(mk("pre_rst_pend", 1, 0, 0, 0, 0, 4'h8, 3, 0, 0, 0, 1, 5, 7'h40, 4'h0));
        @(negedge CLK);
        RST = 1'b1;
        drive(0, 1, 0, A60, 0, 4'h8, 3, 1);
        @(posedge CLK);
        #1;
        check_outs("rst_pend", 0, 0, 7'h00, 4'h0);
        check("rst_pend/fpri", bus.IBUS_DO, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 0, 0, 0, 0, 4'h8, 3, 0);
        @(posedge CLK);
        #1;
        // LVL was cleared, so the still-high source cannot request.
        check_outs("post_rst", 0, 0, 7'h00, 4'h0);
        apply(mk("post_rst_lvl", 1, 1, 1, A60, 32'h0600_0000, 4'h8, 3, 0, 32'h0, 1, 0, 0, 7'h00, 4'h0));
        apply(mk("post_rst_req", 1, 0, 0, 0,   0,             4'h8, 3, 0, 0,     0, 1, 6, 7'h00, 4'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop guards against an unexpected stall of the stimulus thread.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/frt_int_arb.md
FRT_INT_ARB -- requirements
Module: frt_int_arb

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST  in  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have port CE_R  in  1  clock enable; state advances only on cycles with CE_R=1.
REQ-004 SHALL have ports IBUS_A in 32 address, IBUS_DI in 32 write data, IBUS_WE in 1 write, IBUS_REQ in 1 access strobe.
REQ-005 SHALL have ports IBUS_DO out 32 read data and IBUS_ACT out 1, high when the address is in this block.
REQ-006 SHALL have inputs ICI_IRQ, OCIA_IRQ, OCIB_IRQ, OVI_IRQ, 1 bit each, level-sensitive timer sources.
REQ-007 SHALL have input IMASK in 4, the CPU interrupt mask level.
REQ-008 SHALL have input INT_ACK in 1, CPU acceptance of the presented request.
REQ-009 SHALL have outputs INT_REQ out 1, INT_LVL out 4 and INT_VEC out 7.
REQ-010 SHALL have output ACK_SRC out 4, a one-cycle one-hot acknowledge pulse with bits {ICI,OCIA,OCIB,OVI} = [3:0].

Function
REQ-011 SHALL decode register FPRI at 0xFFFFFE60: bits[27:24] LVL, read/write; other bits read 0.
REQ-012 SHALL decode register FVEC at 0xFFFFFE64: bits[30:24] ICV, [22:16] OCV, [14:8] OVV, read/write; other bits read 0.
REQ-013 SHALL write a register on a CE_R cycle with IBUS_REQ=1, IBUS_WE=1 and a matching address; IBUS_ACT SHALL be combinational on address match only.
REQ-014 SHALL return the addressed register on IBUS_DO combinationally while IBUS_ACT=1, and 0 otherwise.
REQ-015 SHALL define a source as eligible when its IRQ=1, LVL!=0 and LVL>IMASK (unsigned compare).
REQ-016 SHALL use fixed priority ICI > OCIA > OCIB > OVI among eligible sources.
REQ-017 SHALL use vector ICV for ICI, OCV for both OCIA and OCIB, and OVV for OVI.
REQ-018 SHALL implement the FSM states IDLE, PEND and HOLD.
REQ-019 IDLE: if any source is eligible in cycle n, SHALL latch the winner and its vector and enter PEND; INT_REQ=1 from cycle n+1.
REQ-020 PEND: SHALL drive INT_REQ=1, INT_LVL=LVL and INT_VEC=latched vector; these SHALL stay stable until exit.
REQ-021 PEND, INT_ACK=1: SHALL pulse ACK_SRC for the latched source for exactly one cycle, drop INT_REQ next cycle and enter HOLD.
REQ-022 PEND, latched source IRQ=0 or no longer eligible, INT_ACK=0 (cancel): SHALL return to IDLE with INT_REQ=0 next cycle and no ACK_SRC pulse.
REQ-023 PEND: if INT_ACK=1 and the source drops in the same cycle, INT_ACK SHALL win (acknowledge path).
REQ-024 PEND: a newly eligible higher-priority source SHALL NOT preempt; it is served after the current source exits.
REQ-025 HOLD: SHALL keep INT_REQ=0 until the acknowledged source IRQ=0, then enter IDLE; this prevents a duplicate request before the handler clears the flag.
REQ-026 IDLE, INT_ACK=1: SHALL be ignored, with no state change and no pulse.
REQ-027 An LVL or FVEC write during PEND SHALL NOT alter the latched INT_VEC; the new LVL SHALL apply to the eligibility check from the next cycle.
REQ-028 INT_LVL and INT_VEC SHALL be 0 whenever INT_REQ=0.
REQ-029 With CE_R=0, all registers and outputs SHALL hold.

Reset
REQ-030 When RST=1 at a clock edge (regardless of CE_R), SHALL go to IDLE with LVL=0, ICV=OCV=OVV=0 and INT_REQ=0.
REQ-031 During reset, INT_LVL=0, INT_VEC=0 and ACK_SRC=0.
REQ-032 Reset asserted in PEND or HOLD SHALL abort without an ACK_SRC pulse.
REQ-033 The first request is possible in the cycle after RST deasserts.

Verification
REQ-034 LVL=5, ICV=0x40, IMASK=3, ICI_IRQ rises at cycle n -> INT_REQ=1, INT_LVL=5, INT_VEC=0x40 at n+1; INT_ACK -> ACK_SRC=4'b1000 for one cycle, then HOLD until ICI_IRQ=0.
REQ-035 OCIB and OVI both high, then INT_ACK -> OCV presented and ACK_SRC=4'b0010; after OCIB clears, OVV is presented.
REQ-036 LVL=3, IMASK=3, OVI_IRQ=1 -> INT_REQ stays 0; a write of LVL=4 -> INT_REQ=1 two cycles after the write.
REQ-037 In PEND, drop OCIA_IRQ without INT_ACK -> INT_REQ=0 next cycle, ACK_SRC stays 0, state IDLE.
REQ-038 Assert RST in PEND -> INT_REQ=0, LVL reads 0 at 0xFFFFFE60, no ACK_SRC pulse.
REQ-039 INT_ACK and the source drop in the same PEND cycle -> ACK_SRC pulse occurs, then IDLE via HOLD.
